// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder stage with a registered carry, LSB first,
// WIDTH add cycles per operation, with a start/busy/done handshake.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_in,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             c_in,
   output logic [WIDTH-1:0] sum_out,
   output logic             carry_out,
   output logic             busy_out,
   output logic             done_out
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] a_reg, b_reg, shreg;
   logic             carry_reg;
   logic [CW-1:0]    cnt;
   logic             s, co, last;

   assign s    = a_reg[0] ^ b_reg[0] ^ carry_reg;
   assign co   = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry_reg) | (b_reg[0] & carry_reg);
   assign last = (cnt == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start_in) state_nx = ADD;
         ADD:     if (last) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Handshake outputs are pure state decodes, so no input reaches them combinationally.
   always_comb begin
      busy_out = (state != IDLE);
      done_out = (state == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg     <= '0;
         b_reg     <= '0;
         shreg     <= '0;
         carry_reg <= 1'b0;
         cnt       <= '0;
         sum_out   <= '0;
         carry_out <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_in) begin
                  a_reg     <= a_in;
                  b_reg     <= b_in;
                  carry_reg <= c_in;
                  cnt       <= '0;
               end
            end
            ADD: begin
               shreg     <= {s, shreg[WIDTH-1:1]};
               a_reg     <= a_reg >> 1;
               b_reg     <= b_reg >> 1;
               carry_reg <= co;
               cnt       <= cnt + 1'b1;
               // Publish only the complete word so sum_out never shows a partial sum.
               if (last) begin
                  sum_out   <= {s, shreg[WIDTH-1:1]};
                  carry_out <= co;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboarded bench for serial_adder at WIDTH=8 and WIDTH=2: directed cases
// followed by 1000 random operations per width against an arithmetic model.
module tb_serial_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit fin [2];

   task automatic chk(input string nm, input int w, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL w%0d %s: got %0h expected %0h", w, nm, act, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : blk
      localparam int W  = (g == 0) ? 8 : 2;
      localparam int RK = (W > 4) ? 3 : 1;

      logic         rst = 1'b1, start = 1'b0, c = 1'b0;
      logic [W-1:0] a = '0, b = '0;
      logic [W-1:0] sum;
      logic         co, busy, done;

      int           cyc = 0;
      int           last_acc = -1000;
      logic [W:0]   last_res = '0;
      bit           mon_en = 1'b0;
      logic [W:0]   expq [$];
      int           accq [$];

      serial_adder #(.WIDTH(W)) dut (
         .clk(clk), .rst(rst), .start_in(start), .a_in(a), .b_in(b), .c_in(c),
         .sum_out(sum), .carry_out(co), .busy_out(busy), .done_out(done)
      );

      always @(posedge clk) cyc <= cyc + 1;

      // Monitor: busy spans accept..accept+W, done at accept+W, result stable otherwise.
      always @(negedge clk) begin
         logic [W:0] e;
         int         acc;
         if (mon_en && !rst) begin
            chk("busy", W, int'(busy), int'(cyc >= last_acc && cyc <= last_acc + W));
            chk("done", W, int'(done), int'(cyc == last_acc + W));
            if (done) begin
               chk("pending_op", W, int'(expq.size() != 0), 1);
               if (expq.size() != 0) begin
                  e   = expq.pop_front();
                  acc = accq.pop_front();
                  chk("result", W, int'({co, sum}), int'(e));
                  chk("latency", W, cyc - acc, W);
                  last_res = e;
               end
            end else begin
               chk("hold", W, int'({co, sum}), int'(last_res));
            end
         end
      end

      // Issue one operation on the first cycle the model says the block is idle.
      task automatic op(input logic [W-1:0] na, input logic [W-1:0] nb, input logic nc,
                        input bit hold, input int gap);
         logic [W:0] e;
         @(negedge clk);
         while (cyc < last_acc + W + 1) @(negedge clk);
         if (!start) repeat (gap) @(negedge clk);
         a = na; b = nb; c = nc; start = 1'b1;
         e = (W+1)'(na) + (W+1)'(nb) + (W+1)'(nc);
         expq.push_back(e);
         accq.push_back(cyc + 1);
         last_acc = cyc + 1;
         if (!hold) begin
            @(negedge clk);
            start = 1'b0;
         end
      endtask

      initial begin
         logic [W-1:0] ones, lo, ra, rb;
         ones = '1;
         lo   = W'((1 << (W / 2)) - 1);
         repeat (2) @(negedge clk);
         chk("rst_sum", W, int'(sum), 0);
         chk("rst_carry", W, int'(co), 0);
         chk("rst_busy", W, int'(busy), 0);
         chk("rst_done", W, int'(done), 0);
         rst = 1'b0;
         mon_en = 1'b1;

         op(lo, W'(1), 1'b0, 1'b0, 0);
         op(ones, W'(1), 1'b0, 1'b0, 0);
         op(ones, ones, 1'b1, 1'b0, 0);

         // start held high; operands change mid-operation
         op(W'(3), W'(5), 1'b0, 1'b1, 0);
         repeat (3) @(negedge clk);
         ra = W'($urandom);
         rb = W'($urandom);
         a = ra; b = rb;
         op(ra, rb, 1'b0, 1'b0, 0);

         // reset in the middle of ADD after a completed result
         op(lo, W'(1), 1'b0, 1'b0, 0);
         op(W'(3), W'(2), 1'b1, 1'b0, 0);
         while (cyc < last_acc + RK) @(negedge clk);
         mon_en = 1'b0;
         rst = 1'b1;
         #1;
         chk("midrst_sum", W, int'(sum), 0);
         chk("midrst_carry", W, int'(co), 0);
         chk("midrst_busy", W, int'(busy), 0);
         chk("midrst_done", W, int'(done), 0);
         expq.delete();
         accq.delete();
         last_acc = -1000;
         last_res = '0;
         @(negedge clk);
         rst = 1'b0;
         mon_en = 1'b1;
         op(W'(1), W'(2), 1'b1, 1'b0, 0);

         // result hold over an idle stretch
         while (cyc < last_acc + W + 1) @(negedge clk);
         repeat (20) @(negedge clk);
         chk("hold20", W, int'({co, sum}), int'(last_res));

         for (int i = 0; i < 1000; i++)
            op(W'($urandom), W'($urandom), 1'($urandom),
               (i < 999) && ($urandom_range(0, 3) == 0), $urandom_range(0, 2));
         while (cyc < last_acc + W + 2) @(negedge clk);
         chk("drained", W, expq.size(), 0);
         fin[g] = 1'b1;
      end
   end

   initial begin
      int n = 0;
      while (!(fin[0] && fin[1]) && n < 60000) begin
         @(negedge clk);
         n++;
      end
      if (!(fin[0] && fin[1])) begin
         checks++;
         errors++;
         $display("FAIL timeout: finished %0d%0d expected 11", fin[0], fin[1]);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
